// File: rtl/uart_tx_retrans.sv
// rtl/uart_tx_retrans.sv - even-parity UART transmitter with ack/resend retransmission
// The serial line is registered, so signal_d is derived from the next state and next bit index.
module uart_tx_retrans #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int ACK_TIMEOUT  = 8,
   parameter int MAX_RETRIES  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data,
   input  logic              send,
   input  logic              ack,
   input  logic              request_resend,
   output logic              signal,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [4:0]        retry_count
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [4:0]    RETRY_MAX = 5'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_ACK
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [DATA_W-1:0] latch_q, latch_d;
   logic              parity_q, parity_d;
   logic [4:0]        retry_q, retry_d;
   logic              signal_q, signal_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              bit_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         tmo_q    <= '0;
         latch_q  <= '0;
         parity_q <= 1'b0;
         retry_q  <= '0;
         signal_q <= 1'b1;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         tmo_q    <= tmo_d;
         latch_q  <= latch_d;
         parity_q <= parity_d;
         retry_q  <= retry_d;
         signal_q <= signal_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      tmo_d    = tmo_q;
      latch_d  = latch_q;
      parity_d = parity_q;
      retry_d  = retry_q;
      done_d   = 1'b0;
      error_d  = 1'b0;
      bit_last = (cnt_q == CNT_LAST);

      unique case (state_q)
         S_IDLE: begin
            if (send) begin
               latch_d  = data;
               parity_d = ^data;
               retry_d  = '0;
               cnt_d    = '0;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (bit_last) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_last) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) state_d = S_PARITY;
               else                   idx_d   = idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (bit_last) begin
               cnt_d   = '0;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_last) begin
               cnt_d   = '0;
               tmo_d   = '0;
               state_d = S_WAIT_ACK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_ACK: begin
            tmo_d = tmo_q + 1'b1;
            // ack outranks both an explicit resend and a coincident timeout
            if (ack) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (request_resend || tmo_q == TMO_LAST) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  cnt_d   = '0;
                  state_d = S_START;
               end else begin
                  error_d = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      unique case (state_d)
         S_START:  signal_d = 1'b0;
         S_DATA:   signal_d = latch_q[idx_d];
         S_PARITY: signal_d = parity_q;
         default:  signal_d = 1'b1;
      endcase
   end

   assign signal      = signal_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign error       = error_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_uart_tx_retrans.sv
// tb/tb_uart_tx_retrans.sv - directed and randomized checks of uart_tx_retrans
// Expected frames are built from the byte; retry/done/error outcomes come from a small retry model.
module tb_uart_tx_retrans;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data;
   logic       send1, send4, ack, rr;
   logic       sig1, busy1, done1, err1;
   logic       sig4, busy4, done4, err4;
   logic [4:0] rc1, rc4;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   uart_tx_retrans #(.DATA_W(8), .CLKS_PER_BIT(1), .ACK_TIMEOUT(8), .MAX_RETRIES(3)) u_dut1 (
      .clk(clk), .reset(rst_n), .data(data), .send(send1), .ack(ack), .request_resend(rr),
      .signal(sig1), .busy(busy1), .done(done1), .error(err1), .retry_count(rc1));

   uart_tx_retrans #(.DATA_W(8), .CLKS_PER_BIT(4), .ACK_TIMEOUT(8), .MAX_RETRIES(3)) u_dut4 (
      .clk(clk), .reset(rst_n), .data(data), .send(send4), .ack(ack), .request_resend(rr),
      .signal(sig4), .busy(busy4), .done(done4), .error(err4), .retry_count(rc4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit use4);
      data = b;
      if (use4) send4 = 1'b1; else send1 = 1'b1;
      tick();
      send1 = 1'b0;
      send4 = 1'b0;
      data  = 8'($urandom);
   endtask

   // Checks one whole frame starting in its first start-bit cycle; ends in the first WAIT_ACK cycle.
   // glitch >= 0 pulses send (with another byte) and ack during that bit on the 1-clock DUT.
   task automatic check_frame(input logic [7:0] b, input bit use4, input int glitch);
      logic [10:0] bits;
      int cpb;
      cpb = use4 ? 4 : 1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
      bits[9]  = ($countones(b) % 2) == 1;
      bits[10] = 1'b1;
      for (int i = 0; i < 11; i++) begin
         for (int c = 0; c < cpb; c++) begin
            chk($sformatf("frame %0h bit%0d c%0d", b, i, c), use4 ? sig4 : sig1, bits[i]);
            chk("busy in frame", use4 ? busy4 : busy1, 1'b1);
            if (i == glitch && c == 0) begin
               send1 = 1'b1;
               data  = ~b;
               ack   = 1'b1;
            end
            tick();
            send1 = 1'b0;
            ack   = 1'b0;
         end
      end
      chk("wait_ack line", use4 ? sig4 : sig1, 1'b1);
   endtask

   task automatic wait_idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         chk("wait line high", sig1, 1'b1);
         chk("wait busy", busy1, 1'b1);
         chk("wait no done", done1, 1'b0);
         tick();
      end
   endtask

   initial begin
      logic [7:0] b;
      int exp_r, act, d;
      bit fin;

      rst_n = 1'b0; data = '0; send1 = 0; send4 = 0; ack = 0; rr = 0;
      repeat (2) tick();
      chk("reset signal", sig1, 1'b1);
      chk("reset busy", busy1, 1'b0);
      chk("reset done", done1, 1'b0);
      chk("reset error", err1, 1'b0);
      chk("reset retry", rc1, 5'd0);
      chk("reset signal4", sig4, 1'b1);
      rst_n = 1'b1;
      tick();

      // ack in IDLE is ignored
      ack = 1'b1; tick(); ack = 1'b0;
      chk("idle ack busy", busy1, 1'b0);
      chk("idle ack done", done1, 1'b0);

      // basic frame 0xA5, then ack
      send_byte(8'hA5, 0);
      check_frame(8'hA5, 0, -1);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("A5 done", done1, 1'b1);
      chk("A5 busy", busy1, 1'b0);
      chk("A5 retry", rc1, 5'd0);
      tick();
      chk("A5 done pulse end", done1, 1'b0);

      // parity 1 byte, explicit resend then ack
      send_byte(8'h07, 0);
      check_frame(8'h07, 0, -1);
      rr = 1'b1; tick(); rr = 1'b0;
      chk("07 retry after resend", rc1, 5'd1);
      check_frame(8'h07, 0, -1);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("07 done", done1, 1'b1);
      chk("07 retry held", rc1, 5'd1);

      // ignored send/ack mid-frame, then ack+resend together
      tick();
      send_byte(8'h5A, 0);
      check_frame(8'h5A, 0, 4);
      rr = 1'b1; tick(); rr = 1'b0;
      chk("glitch retry", rc1, 5'd1);
      check_frame(8'h5A, 0, -1);
      ack = 1'b1; rr = 1'b1; tick(); ack = 1'b0; rr = 1'b0;
      chk("ack wins done", done1, 1'b1);
      chk("ack wins busy", busy1, 1'b0);
      chk("ack wins retry", rc1, 5'd1);
      tick();
      chk("no retransmit", busy1, 1'b0);

      // timeout path to error
      send_byte(8'hC3, 0);
      for (int r = 0; r < 4; r++) begin
         chk("timeout retry", rc1, 5'(r));
         check_frame(8'hC3, 0, -1);
         wait_idle_cycles(8);
      end
      chk("timeout error", err1, 1'b1);
      chk("timeout busy", busy1, 1'b0);
      chk("timeout done", done1, 1'b0);
      chk("timeout retry final", rc1, 5'd3);
      tick();
      chk("error pulse end", err1, 1'b0);

      // randomized bytes and far-end responses against the retry model
      for (int it = 0; it < 8; it++) begin
         b = 8'($urandom);
         send_byte(b, 0);
         exp_r = 0;
         fin = 0;
         while (!fin) begin
            chk("rand retry", rc1, 5'(exp_r));
            check_frame(b, 0, -1);
            act = $urandom_range(0, 2);
            d   = $urandom_range(0, 7);
            if (act == 0) begin
               wait_idle_cycles(d);
               ack = 1'b1; tick(); ack = 1'b0;
               chk("rand done", done1, 1'b1);
               chk("rand done busy", busy1, 1'b0);
               chk("rand done retry", rc1, 5'(exp_r));
               fin = 1;
            end else begin
               if (act == 1) begin
                  wait_idle_cycles(d);
                  rr = 1'b1; tick(); rr = 1'b0;
               end else begin
                  wait_idle_cycles(8);
               end
               if (exp_r < 3) begin
                  exp_r++;
               end else begin
                  chk("rand error", err1, 1'b1);
                  chk("rand error busy", busy1, 1'b0);
                  chk("rand error done", done1, 1'b0);
                  fin = 1;
               end
            end
         end
         tick();
         chk("rand pulses clear", {done1, err1}, 2'b00);
      end

      // reset mid-frame on the 4-clock-per-bit instance
      send_byte(8'hFF, 1);
      repeat (10) tick();
      chk("pre-reset busy4", busy4, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset signal4", sig4, 1'b1);
      chk("async reset busy4", busy4, 1'b0);
      chk("async reset retry4", rc4, 5'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("after reset idle4", busy4, 1'b0);
      send_byte(8'h3C, 1);
      check_frame(8'h3C, 1, -1);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("3C done4", done4, 1'b1);
      chk("3C busy4", busy4, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
